match_collect_buffer: RTL and testbench

//  Downstream of the keypoint matcher. Collects match pairs (src/dst x, y, depth) as the matcher emits them,

---
 rtl/match_collect_buffer.sv | 154 +++++++++++++++
 tb/tb_match_collect_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_collect_buffer.sv
// match_collect_buffer: gathers matcher pairs into per-frame sets using two
// ping-pong banks, then replays each closed set over a valid/ready stream.
// One bank fills while the other drains. Pairs without depth can be filtered.
module match_collect_buffer #(
  parameter int DEPTH       = 500,
  parameter int AW          = 9,
  parameter int FILTER_ZDEP = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_end,
  input  logic       i_valid,
  input  logic [9:0] i_src_coor_x,
  input  logic [9:0] i_src_coor_y,
  input  logic [9:0] i_src_depth,
  input  logic [9:0] i_dst_coor_x,
  input  logic [9:0] i_dst_coor_y,
  input  logic [9:0] i_dst_depth,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [9:0] o_src_coor_x,
  output logic [9:0] o_src_coor_y,
  output logic [9:0] o_src_depth,
  output logic [9:0] o_dst_coor_x,
  output logic [9:0] o_dst_coor_y,
  output logic [9:0] o_dst_depth,
  output logic       o_last,
  output logic [9:0] o_set_count,
  output logic       o_set_done,
  output logic       o_abort,
  output logic       o_overflow
);

  // Pointers carry one extra bit so a completely full bank (ptr == DEPTH)
  // stays representable even when DEPTH is a power of two.
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DRAIN} rd_state_t;

  // Both banks live in one array; the top address bit selects the bank.
  logic [59:0]   mem [2**PW];
  logic          wr_bank;
  logic          rd_bank;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_closing;
  logic [PW-1:0] rd_idx;
  logic [9:0]    set_count;
  logic [59:0]   out_pair;
  logic [59:0]   in_pair;
  logic          keep;
  logic          wr_full;
  logic          wr_en;
  rd_state_t     rd_state;

  assign in_pair = {i_src_coor_x, i_src_coor_y, i_src_depth,
                    i_dst_coor_x, i_dst_coor_y, i_dst_depth};
  assign keep    = !((FILTER_ZDEP != 0) && (i_src_depth == 10'd0 || i_dst_depth == 10'd0));
  assign wr_full = (wr_ptr == DEPTH_PTR);
  assign wr_en   = i_valid && keep && !wr_full;
  // Fill level including a pair arriving together with the frame-end pulse,
  // since that pair still belongs to the set being closed.
  assign wr_ptr_closing = wr_en ? wr_ptr + PW'(1) : wr_ptr;

  assign {o_src_coor_x, o_src_coor_y, o_src_depth,
          o_dst_coor_x, o_dst_coor_y, o_dst_depth} = out_pair;
  assign o_set_count = set_count;

  // Store kept pairs into the bank currently being filled.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_en) begin
      mem[{wr_bank, wr_ptr[AW-1:0]}] <= in_pair;
    end
  end

  // Fill pointer, bank flip on frame end, and overflow pulse for dropped pairs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= i_valid && keep && wr_full;
      if (i_frame_end) begin
        wr_bank <= ~wr_bank;
        wr_ptr  <= '0;
      end else begin
        wr_ptr <= wr_ptr_closing;
      end
    end
  end

  // Read FSM: takes over the closed bank at a swap and replays it one beat per
  // accepted handshake; a swap during a replay abandons the old set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state   <= R_IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      set_count  <= '0;
      out_pair   <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_set_done <= 1'b0;
      o_abort    <= 1'b0;
    end else begin
      o_set_done <= 1'b0;
      o_abort    <= 1'b0;
      if (i_frame_end) begin
        rd_bank   <= wr_bank;
        set_count <= 10'(wr_ptr_closing);
        rd_idx    <= '0;
        o_valid   <= 1'b0;
        o_last    <= 1'b0;
        rd_state  <= R_LOAD;
        if (rd_state != R_IDLE) begin
          o_abort <= 1'b1;
        end
      end else begin
        case (rd_state)
          R_IDLE: rd_state <= R_IDLE;
          R_LOAD: begin
            if (set_count == 10'd0) begin
              o_set_done <= 1'b1;
              rd_state   <= R_IDLE;
            end else begin
              out_pair <= mem[{rd_bank, {AW{1'b0}}}];
              o_valid  <= 1'b1;
              o_last   <= (set_count == 10'd1);
              rd_idx   <= PW'(1);
              rd_state <= R_DRAIN;
            end
          end
          R_DRAIN: begin
            if (o_valid && i_ready) begin
              if (o_last) begin
                o_valid    <= 1'b0;
                o_last     <= 1'b0;
                o_set_done <= 1'b1;
                rd_state   <= R_IDLE;
              end else begin
                out_pair <= mem[{rd_bank, rd_idx[AW-1:0]}];
                o_last   <= (10'(rd_idx + PW'(1)) == set_count);
                rd_idx   <= rd_idx + PW'(1);
              end
            end
          end
          default: rd_state <= R_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_match_collect_buffer.sv
// Testbench for match_collect_buffer: directed scenarios followed by random
// traffic, checked by a scoreboard fed from a set-level reference model.
module tb_match_collect_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic       i_clk;
  logic       i_rst;
  logic       i_frame_end;
  logic       i_valid;
  logic [9:0] i_src_coor_x, i_src_coor_y, i_src_depth;
  logic [9:0] i_dst_coor_x, i_dst_coor_y, i_dst_depth;
  logic       i_ready;
  logic       o_valid;
  logic [9:0] o_src_coor_x, o_src_coor_y, o_src_depth;
  logic [9:0] o_dst_coor_x, o_dst_coor_y, o_dst_depth;
  logic       o_last;
  logic [9:0] o_set_count;
  logic       o_set_done;
  logic       o_abort;
  logic       o_overflow;

  logic [59:0] out_pair;
  logic [79:0] all_out;

  int checks = 0;
  int errors = 0;
  int exp_ovf = 0;
  int dut_ovf = 0;
  int dut_done = 0;
  int dut_abort = 0;
  int ready_mode = 0;
  int ovf0, done0, abort0;

  // Reference model state: the set being filled, plus closed sets awaiting replay.
  logic [59:0] cur_set[$];
  logic [59:0] exp_beats[$];
  int          set_rem[$];
  int          set_size[$];

  match_collect_buffer #(.DEPTH(DEPTH), .AW(AW), .FILTER_ZDEP(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_end(i_frame_end), .i_valid(i_valid),
    .i_src_coor_x(i_src_coor_x), .i_src_coor_y(i_src_coor_y), .i_src_depth(i_src_depth),
    .i_dst_coor_x(i_dst_coor_x), .i_dst_coor_y(i_dst_coor_y), .i_dst_depth(i_dst_depth),
    .i_ready(i_ready), .o_valid(o_valid),
    .o_src_coor_x(o_src_coor_x), .o_src_coor_y(o_src_coor_y), .o_src_depth(o_src_depth),
    .o_dst_coor_x(o_dst_coor_x), .o_dst_coor_y(o_dst_coor_y), .o_dst_depth(o_dst_depth),
    .o_last(o_last), .o_set_count(o_set_count), .o_set_done(o_set_done),
    .o_abort(o_abort), .o_overflow(o_overflow)
  );

  assign out_pair = {o_src_coor_x, o_src_coor_y, o_src_depth,
                     o_dst_coor_x, o_dst_coor_y, o_dst_depth};
  assign all_out  = {5'd0, o_valid, o_last, o_set_done, o_abort, o_overflow, o_set_count, out_pair};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [59:0] mkPair(input logic [9:0] sx, input logic [9:0] sy,
                                         input logic [9:0] sd, input logic [9:0] dx,
                                         input logic [9:0] dy, input logic [9:0] dd);
    return {sx, sy, sd, dx, dy, dd};
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and advance the reference model.
  task automatic applyStimulus(input logic v, input logic fe, input logic [59:0] p);
    @(posedge i_clk);
    #1;
    i_valid     = v;
    i_frame_end = fe;
    {i_src_coor_x, i_src_coor_y, i_src_depth, i_dst_coor_x, i_dst_coor_y, i_dst_depth} = p;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      2:       i_ready = 1'b0;
      default: i_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (v && p[39:30] != 10'd0 && p[9:0] != 10'd0) begin
      if (cur_set.size() < DEPTH) cur_set.push_back(p);
      else exp_ovf++;
    end
    if (fe) begin
      set_size.push_back(cur_set.size());
      set_rem.push_back(cur_set.size());
      foreach (cur_set[k]) exp_beats.push_back(cur_set[k]);
      cur_set.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 60'd0);
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      i_rst       = 1'b1;
      i_valid     = 1'($urandom_range(0, 1));
      i_frame_end = 1'($urandom_range(0, 1));
      i_ready     = 1'($urandom_range(0, 1));
      {i_src_coor_x, i_src_coor_y, i_src_depth} = 30'($urandom);
      {i_dst_coor_x, i_dst_coor_y, i_dst_depth} = 30'($urandom);
      if (i == 0) begin
        cur_set.delete();
        exp_beats.delete();
        set_rem.delete();
        set_size.delete();
      end else begin
        checkOutput("reset_outputs", all_out, 80'd0);
      end
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_frame_end = 1'b0;
    i_ready = 1'b1;
    checkOutput("reset_outputs", all_out, 80'd0);
  endtask

  // Monitor: compares every presented beat and every pulse against the scoreboard.
  always @(negedge i_clk) begin
    if (o_overflow) dut_ovf++;
    if (!i_rst) begin
      if (o_valid) begin
        if (set_rem.size() == 0 || set_rem[0] == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=no_beat", out_pair);
        end else begin
          checkOutput("beat_data", 80'(out_pair), 80'(exp_beats[0]));
          checkOutput("beat_last", 80'(o_last), 80'(set_rem[0] == 1));
          checkOutput("beat_count", 80'(o_set_count), 80'(set_size[0]));
          if (i_ready) begin
            void'(exp_beats.pop_front());
            set_rem[0] = set_rem[0] - 1;
          end
        end
      end
      if (o_set_done) begin
        dut_done++;
        if (set_rem.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          checkOutput("done_remaining", 80'(set_rem[0]), 80'd0);
          checkOutput("done_count", 80'(o_set_count), 80'(set_size[0]));
          for (int k = 0; k < set_rem[0]; k++) void'(exp_beats.pop_front());
          void'(set_rem.pop_front());
          void'(set_size.pop_front());
        end
      end
      if (o_abort) begin
        dut_abort++;
        checkOutput("abort_valid", 80'(o_valid), 80'd0);
        if (set_rem.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_abort actual=1 required=0");
        end else begin
          for (int k = 0; k < set_rem[0]; k++) void'(exp_beats.pop_front());
          void'(set_rem.pop_front());
          void'(set_size.pop_front());
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_frame_end = 1'b0;
    i_ready = 1'b1;
    {i_src_coor_x, i_src_coor_y, i_src_depth, i_dst_coor_x, i_dst_coor_y, i_dst_depth} = 60'd0;

    $display("[TB] reset with random inputs");
    doReset();
    idle(2);

    $display("[TB] three pairs at full rate");
    ready_mode = 0;
    done0 = dut_done;
    for (int x = 1; x <= 3; x++) applyStimulus(1'b1, 1'b0, mkPair(10'(x), 10'd7, 10'd5, 10'(x + 100), 10'd8, 10'd5));
    applyStimulus(1'b0, 1'b1, 60'd0);
    applyStimulus(1'b0, 1'b0, 60'd0);
    checkOutput("latency_early", 80'(o_valid), 80'd0);
    checkOutput("swap_count_3", 80'(o_set_count), 80'd3);
    applyStimulus(1'b0, 1'b0, 60'd0);
    checkOutput("latency_first", 80'(o_valid), 80'd1);
    idle(8);
    checkOutput("t2_done_pulses", 80'(dut_done - done0), 80'd1);

    $display("[TB] backpressure with toggling ready");
    ready_mode = 1;
    done0 = dut_done;
    for (int x = 1; x <= 4; x++) applyStimulus(1'b1, 1'b0, mkPair(10'(x * 3), 10'(x), 10'd9, 10'd1, 10'(x * 5), 10'd2));
    applyStimulus(1'b0, 1'b1, 60'd0);
    idle(16);
    checkOutput("t3_done_pulses", 80'(dut_done - done0), 80'd1);

    $display("[TB] zero-depth filter");
    ready_mode = 0;
    applyStimulus(1'b1, 1'b0, mkPair(10'd11, 10'd1, 10'd5, 10'd21, 10'd1, 10'd5));
    applyStimulus(1'b1, 1'b0, mkPair(10'd12, 10'd2, 10'd0, 10'd22, 10'd2, 10'd7));
    applyStimulus(1'b1, 1'b0, mkPair(10'd13, 10'd3, 10'd9, 10'd23, 10'd3, 10'd0));
    applyStimulus(1'b1, 1'b0, mkPair(10'd14, 10'd4, 10'd3, 10'd24, 10'd4, 10'd4));
    applyStimulus(1'b0, 1'b1, 60'd0);
    applyStimulus(1'b0, 1'b0, 60'd0);
    checkOutput("filter_count", 80'(o_set_count), 80'd2);
    idle(8);

    $display("[TB] bank full and coincident frame end");
    ovf0 = dut_ovf;
    for (int x = 1; x <= 5; x++) applyStimulus(1'b1, 1'b0, mkPair(10'(x), 10'(x), 10'd1, 10'(x), 10'(x), 10'd1));
    applyStimulus(1'b1, 1'b1, mkPair(10'd6, 10'd6, 10'd1, 10'd6, 10'd6, 10'd1));
    applyStimulus(1'b0, 1'b0, 60'd0);
    checkOutput("full_count", 80'(o_set_count), 80'd4);
    idle(8);
    checkOutput("overflow_pulses", 80'(dut_ovf - ovf0), 80'd2);
    applyStimulus(1'b1, 1'b0, mkPair(10'd40, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5));
    applyStimulus(1'b1, 1'b0, mkPair(10'd41, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5));
    applyStimulus(1'b1, 1'b1, mkPair(10'd42, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5));
    applyStimulus(1'b0, 1'b0, 60'd0);
    checkOutput("coincident_count", 80'(o_set_count), 80'd3);
    idle(8);

    $display("[TB] empty set and swap mid-drain");
    done0 = dut_done;
    applyStimulus(1'b0, 1'b1, 60'd0);
    idle(6);
    checkOutput("empty_done_pulses", 80'(dut_done - done0), 80'd1);
    ready_mode = 2;
    done0 = dut_done;
    abort0 = dut_abort;
    for (int x = 1; x <= 3; x++) applyStimulus(1'b1, 1'b0, mkPair(10'(x + 50), 10'd1, 10'd1, 10'd1, 10'd1, 10'd1));
    applyStimulus(1'b0, 1'b1, 60'd0);
    idle(4);
    applyStimulus(1'b1, 1'b0, mkPair(10'd60, 10'd2, 10'd2, 10'd2, 10'd2, 10'd2));
    applyStimulus(1'b1, 1'b1, mkPair(10'd61, 10'd2, 10'd2, 10'd2, 10'd2, 10'd2));
    ready_mode = 0;
    idle(10);
    checkOutput("abort_pulses", 80'(dut_abort - abort0), 80'd1);
    checkOutput("after_abort_done", 80'(dut_done - done0), 80'd1);

    $display("[TB] random traffic");
    ready_mode = 3;
    for (int c = 0; c < 2500; c++) begin
      logic [9:0] sd, dd;
      sd = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      dd = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      if (c == 1200) begin
        doReset();
        ready_mode = 3;
      end
      applyStimulus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 11) == 0),
                    mkPair(10'($urandom), 10'($urandom), sd, 10'($urandom), 10'($urandom), dd));
    end
    ready_mode = 0;
    idle(30);
    checkOutput("final_beats_left", 80'(exp_beats.size()), 80'd0);
    checkOutput("final_sets_left", 80'(set_rem.size()), 80'd0);
    checkOutput("overflow_total", 80'(dut_ovf), 80'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
